// File: rtl/serial_word_receiver_pkg.sv
// Shared types and constants for the serial word receiver.
package serial_word_receiver_pkg;

  // Receiver framing state. SHIFT means a frame is in progress.
  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_t;

  // Bit order codes. The order is latched from lsb_first at frame start.
  localparam logic RX_ORDER_MSB = 1'b0;
  localparam logic RX_ORDER_LSB = 1'b1;

endpackage

// File: rtl/serial_word_receiver_if.sv
// Bus interface between the serial source, the receiver and the word consumer.
//
// Handshake: word_out is offered while word_valid=1. A word is transferred on
// the rising clk edge where word_valid=1 and word_ready=1. While word_valid=1
// and word_ready=0, word_out holds its value. The serial side has no ready:
// every sin_valid=1 cycle delivers one bit.
interface serial_word_receiver_if
  import serial_word_receiver_pkg::*;
#(
  parameter int WIDTH = 4
);
  logic             sin;
  logic             sin_valid;
  logic             frame_start;
  logic             lsb_first;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             overrun;
  logic             overrun_clr;
  logic             busy;
  rx_state_t        dbg_state;

  // Receiver side.
  modport slave (
    input  sin, sin_valid, frame_start, lsb_first, word_ready, overrun_clr,
    output word_out, word_valid, overrun, busy, dbg_state
  );

  // Source and consumer side.
  modport master (
    output sin, sin_valid, frame_start, lsb_first, word_ready, overrun_clr,
    input  word_out, word_valid, overrun, busy, dbg_state
  );
endinterface

// File: rtl/serial_word_receiver_rx_output_slot.sv
// One-entry valid/ready holding register. A new word loads when the slot is
// empty or is being emptied on the same edge; otherwise it is dropped and the
// sticky overrun flag is raised.
module rx_output_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_ready,
  input  logic             i_ovr_clr,
  output logic [WIDTH-1:0] o_word,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_overrun;
  logic             w_accept;
  logic             w_can_load;

  assign w_accept   = r_valid & i_ready;
  assign w_can_load = ~r_valid | i_ready;

  // Holding register: load wins over acceptance so back-to-back words keep valid high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word  <= '0;
      r_valid <= 1'b0;
    end else if (i_load && w_can_load) begin
      r_word  <= i_word;
      r_valid <= 1'b1;
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky overrun: a drop sets it, clear only takes effect without a drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (i_load && !w_can_load) begin
      r_overrun <= 1'b1;
    end else if (i_ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign o_word    = r_word;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel receiver: framing FSM, bit counter and shift register,
// feeding a one-entry output slot.
module serial_word_receiver
  import serial_word_receiver_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic                   clk,
  input logic                   reset,
  serial_word_receiver_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  rx_state_t        r_state, w_state_next;
  logic [WIDTH-1:0] r_sr, w_sr_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic             r_order, w_order_next;

  logic             w_start;
  logic             w_order_eff;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_shift;
  logic             w_complete;

  // A frame start restarts from an empty register with the freshly sampled order.
  assign w_start     = bus.sin_valid & bus.frame_start;
  assign w_order_eff = w_start ? bus.lsb_first : r_order;
  assign w_base      = w_start ? '0 : r_sr;
  assign w_shift     = (w_order_eff == RX_ORDER_LSB) ? {bus.sin, w_base[WIDTH-1:1]}
                                                     : {w_base[WIDTH-2:0], bus.sin};
  // Frame start has priority: an aborted frame never completes.
  assign w_complete  = (r_state == RX_SHIFT) & bus.sin_valid & ~bus.frame_start &
                       (r_cnt == CW'(WIDTH - 1));

  // State, shift register, counter and order register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RX_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_order <= RX_ORDER_MSB;
    end else begin
      r_state <= w_state_next;
      r_sr    <= w_sr_next;
      r_cnt   <= w_cnt_next;
      r_order <= w_order_next;
    end
  end

  // Next-state logic: gaps (sin_valid=0) hold everything.
  always_comb begin
    w_state_next = r_state;
    w_sr_next    = r_sr;
    w_cnt_next   = r_cnt;
    w_order_next = r_order;
    if (w_start) begin
      w_state_next = RX_SHIFT;
      w_sr_next    = w_shift;
      w_cnt_next   = CW'(1);
      w_order_next = bus.lsb_first;
    end else if (r_state == RX_SHIFT && bus.sin_valid) begin
      w_sr_next = w_shift;
      if (w_complete) begin
        w_state_next = RX_IDLE;
        w_cnt_next   = '0;
      end else begin
        w_cnt_next = r_cnt + CW'(1);
      end
    end
  end

  rx_output_slot #(.WIDTH(WIDTH)) u_slot (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_complete),
    .i_word    (w_shift),
    .i_ready   (bus.word_ready),
    .i_ovr_clr (bus.overrun_clr),
    .o_word    (bus.word_out),
    .o_valid   (bus.word_valid),
    .o_overrun (bus.overrun)
  );

  assign bus.busy      = (r_state == RX_SHIFT);
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver (WIDTH=4) with a queue scoreboard.
module tb_serial_word_receiver;
  import serial_word_receiver_pkg::*;

  localparam int W = 4;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [W-1:0] exp_q[$];

  serial_word_receiver_if #(.WIDTH(W)) bus ();

  serial_word_receiver #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted word must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && bus.word_valid && bus.word_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word: got=%0h expected=none at %0t", bus.word_out, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (bus.word_out !== e) begin
          bad++;
          $display("FAIL word_out: got=%0h expected=%0h at %0t", bus.word_out, e, $time);
        end
      end
    end
  end

  // Drivers: each starts and ends 1 time unit after a rising edge.
  task automatic drive_bit(input logic b, input logic fs, input logic ord);
    bus.sin         = b;
    bus.sin_valid   = 1'b1;
    bus.frame_start = fs;
    bus.lsb_first   = ord;
    @(posedge clk); #1;
    bus.sin_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.sin         = 1'b0;
  endtask

  // Sends seq[3] first. gap idle cycles between bits; rdy_last raises ready with the last bit.
  task automatic send_frame(input logic [3:0] seq, input logic ord, input int gap, input bit rdy_last);
    for (int i = 3; i >= 0; i--) begin
      if (i == 0 && rdy_last) bus.word_ready = 1'b1;
      drive_bit(seq[i], (i == 3), ord);
      if (i != 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check("busy_gap", 32'(bus.busy), 32'd1);
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.sin         = 1'b0;
    bus.sin_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.lsb_first   = 1'b0;
    bus.word_ready  = 1'b0;
    bus.overrun_clr = 1'b0;
    idle(2);
    check("rst_word_out", 32'(bus.word_out), 32'd0);
    check("rst_valid", 32'(bus.word_valid), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(RX_IDLE));
    reset = 1'b0;
    bus.word_ready = 1'b1;
    idle(1);

    // IDLE ignores bits without frame_start.
    drive_bit(1'b1, 1'b0, 1'b0);
    check("idle_ignore_busy", 32'(bus.busy), 32'd0);

    // MSB-first 1,0,1,1 -> B, valid one cycle after the last bit.
    exp_q.push_back(4'hB);
    send_frame(4'b1011, 1'b0, 0, 1'b0);
    @(negedge clk);
    check("msb_valid", 32'(bus.word_valid), 32'd1);
    check("msb_word", 32'(bus.word_out), 32'hB);
    check("msb_busy_after", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check("msb_valid_drop", 32'(bus.word_valid), 32'd0);

    // LSB-first 1,0,1,1 -> D, back to back then with 3-cycle gaps.
    exp_q.push_back(4'hD);
    send_frame(4'b1011, 1'b1, 0, 1'b0);
    idle(2);
    exp_q.push_back(4'hD);
    send_frame(4'b1011, 1'b1, 3, 1'b0);
    @(negedge clk);
    check("lsb_gap_word", 32'(bus.word_out), 32'hD);
    idle(2);

    // Back-pressure: A held, 5 dropped, overrun set then cleared.
    bus.word_ready = 1'b0;
    exp_q.push_back(4'hA);
    send_frame(4'b1010, 1'b0, 0, 1'b0);
    send_frame(4'b0101, 1'b0, 0, 1'b0);
    idle(1);
    @(negedge clk);
    check("bp_word_held", 32'(bus.word_out), 32'hA);
    check("bp_valid", 32'(bus.word_valid), 32'd1);
    check("bp_overrun", 32'(bus.overrun), 32'd1);
    @(posedge clk); #1;
    bus.word_ready = 1'b1;
    idle(1);
    check("bp_overrun_sticky", 32'(bus.overrun), 32'd1);
    check("bp_valid_after_accept", 32'(bus.word_valid), 32'd0);
    bus.overrun_clr = 1'b1;
    idle(1);
    bus.overrun_clr = 1'b0;
    check("bp_overrun_clr", 32'(bus.overrun), 32'd0);

    // Abort: two bits, then a new frame 0,1,1,0 -> only 6.
    drive_bit(1'b1, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0);
    exp_q.push_back(4'h6);
    send_frame(4'b0110, 1'b0, 0, 1'b0);
    idle(3);
    check("abort_overrun", 32'(bus.overrun), 32'd0);

    // Reset mid-frame with a full slot and overrun set; everything returns to 0.
    bus.word_ready = 1'b0;
    send_frame(4'b1010, 1'b0, 0, 1'b0);
    send_frame(4'b0101, 1'b0, 0, 1'b0);
    drive_bit(1'b1, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b0, 1'b0);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    check("pre_rst_overrun", 32'(bus.overrun), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_word_out", 32'(bus.word_out), 32'd0);
    check("mid_rst_valid", 32'(bus.word_valid), 32'd0);
    check("mid_rst_overrun", 32'(bus.overrun), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.word_ready = 1'b1;
    exp_q.push_back(4'hC);
    send_frame(4'b1100, 1'b0, 0, 1'b0);
    idle(2);

    // Back-to-back: slot full with 3, ready rises on 9's last bit.
    bus.word_ready = 1'b0;
    exp_q.push_back(4'h3);
    send_frame(4'b0011, 1'b0, 0, 1'b0);
    exp_q.push_back(4'h9);
    send_frame(4'b1001, 1'b0, 0, 1'b1);
    check("b2b_valid", 32'(bus.word_valid), 32'd1);
    check("b2b_word", 32'(bus.word_out), 32'h9);
    check("b2b_overrun", 32'(bus.overrun), 32'd0);
    idle(3);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
